// File: rtl/resp_tx_pkg.sv
// Shared constants and types for the status-report encoder:
// ASCII glyphs, report-select and FSM encodings, message lengths.
package resp_tx_pkg;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_COLON      = 8'h3A;
    localparam logic [7:0] ASCII_PERCENT    = 8'h25;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_H          = 8'h48;
    localparam logic [7:0] ASCII_T          = 8'h54;
    localparam logic [7:0] ASCII_C          = 8'h43;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    // Body lengths exclude the line terminator.
    localparam int unsigned TIME_BODY_LEN = 8;
    localparam int unsigned DHT_BODY_LEN  = 11;
    localparam int unsigned IDX_W         = 4;

    typedef enum logic {
        REPORT_TIME = 1'b0,
        REPORT_DHT  = 1'b1
    } report_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic logic [IDX_W-1:0] msg_last_idx(input report_sel_e sel, input bit crlf);
        int unsigned len;
        len = (sel == REPORT_DHT) ? DHT_BODY_LEN : TIME_BODY_LEN;
        len = len + (crlf ? 32'd2 : 32'd1);
        return IDX_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/bin2ascii_2dig.sv
// Binary to two ASCII decimal digits, leading zero kept, saturating at 99.
module bin2ascii_2dig (
    input  logic [7:0] bin,
    output logic [7:0] tens_ascii,
    output logic [7:0] ones_ascii
);
    import resp_tx_pkg::*;

    logic [7:0] sat;
    logic [7:0] tens;
    logic [7:0] ones;

    always_comb begin
        sat        = (bin > 8'd99) ? 8'd99 : bin;
        tens       = sat / 8'd10;
        ones       = sat % 8'd10;
        tens_ascii = ASCII_DIGIT_BASE + tens;
        ones_ascii = ASCII_DIGIT_BASE + ones;
    end

endmodule

// File: rtl/resp_tx_cu.sv
// Status-report encoder: snapshots watch/DHT fields on request and streams
// the formatted ASCII line into the UART TX FIFO one byte per accepted cycle.
module resp_tx_cu #(
    parameter bit P_EOL_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_report_req,
    input  logic       i_report_sel,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [7:0] i_humid,
    input  logic [7:0] i_temp,
    input  logic       i_fifo_full,
    output logic       o_fifo_push,
    output logic [7:0] o_fifo_wr_data,
    output logic       o_busy
);
    import resp_tx_pkg::*;

    state_e            state;
    report_sel_e       sel_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;
    logic [4:0]        hour_q;
    logic [5:0]        min_q;
    logic [5:0]        sec_q;
    logic [7:0]        humid_q;
    logic [7:0]        temp_q;
    logic [7:0]        cur_byte;
    logic [7:0]        eol_first;

    logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
    logic [7:0] humid_t, humid_o, temp_t, temp_o;

    bin2ascii_2dig u_hour  (.bin({3'b000, hour_q}), .tens_ascii(hour_t),  .ones_ascii(hour_o));
    bin2ascii_2dig u_min   (.bin({2'b00, min_q}),   .tens_ascii(min_t),   .ones_ascii(min_o));
    bin2ascii_2dig u_sec   (.bin({2'b00, sec_q}),   .tens_ascii(sec_t),   .ones_ascii(sec_o));
    bin2ascii_2dig u_humid (.bin(humid_q),          .tens_ascii(humid_t), .ones_ascii(humid_o));
    bin2ascii_2dig u_temp  (.bin(temp_q),           .tens_ascii(temp_t),  .ones_ascii(temp_o));

    assign last_idx  = msg_last_idx(sel_q, P_EOL_CRLF);
    assign eol_first = P_EOL_CRLF ? ASCII_CR : ASCII_LF;

    always_comb begin
        cur_byte = '0;
        if (sel_q == REPORT_TIME) begin
            case (idx)
                4'd0:    cur_byte = hour_t;
                4'd1:    cur_byte = hour_o;
                4'd2:    cur_byte = ASCII_COLON;
                4'd3:    cur_byte = min_t;
                4'd4:    cur_byte = min_o;
                4'd5:    cur_byte = ASCII_COLON;
                4'd6:    cur_byte = sec_t;
                4'd7:    cur_byte = sec_o;
                4'd8:    cur_byte = eol_first;
                4'd9:    cur_byte = ASCII_LF;
                default: cur_byte = '0;
            endcase
        end else begin
            case (idx)
                4'd0:    cur_byte = ASCII_H;
                4'd1:    cur_byte = ASCII_COLON;
                4'd2:    cur_byte = humid_t;
                4'd3:    cur_byte = humid_o;
                4'd4:    cur_byte = ASCII_PERCENT;
                4'd5:    cur_byte = ASCII_SPACE;
                4'd6:    cur_byte = ASCII_T;
                4'd7:    cur_byte = ASCII_COLON;
                4'd8:    cur_byte = temp_t;
                4'd9:    cur_byte = temp_o;
                4'd10:   cur_byte = ASCII_C;
                4'd11:   cur_byte = eol_first;
                4'd12:   cur_byte = ASCII_LF;
                default: cur_byte = '0;
            endcase
        end
    end

    // Push is combinational so a byte leaves in the same cycle the FIFO has room.
    always_comb begin
        o_fifo_push    = (state == ST_SEND) && !i_fifo_full;
        o_fifo_wr_data = o_fifo_push ? cur_byte : '0;
        o_busy         = (state == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            sel_q   <= REPORT_TIME;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            humid_q <= '0;
            temp_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_report_req) begin
                        sel_q   <= report_sel_e'(i_report_sel);
                        hour_q  <= i_hour;
                        min_q   <= i_min;
                        sec_q   <= i_sec;
                        humid_q <= i_humid;
                        temp_q  <= i_temp;
                        idx     <= '0;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!i_fifo_full) begin
                        if (idx == last_idx) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_tx_cu.sv
// Self-checking bench for resp_tx_cu: one CRLF and one LF instance, checked
// against a string-building reference model of the report formats.
module tb_resp_tx_cu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] hour = '0;
    logic [5:0] mins = '0;
    logic [5:0] secs = '0;
    logic [7:0] humid = '0;
    logic [7:0] temp = '0;

    logic       req_c = 1'b0, sel_c = 1'b0, full_c = 1'b0;
    logic       req_l = 1'b0, sel_l = 1'b0, full_l = 1'b0;
    logic       push_c, busy_c, push_l, busy_l;
    logic [7:0] data_c, data_l;

    resp_tx_cu #(.P_EOL_CRLF(1'b1)) dut_crlf (
        .clk(clk), .rst(rst), .i_report_req(req_c), .i_report_sel(sel_c),
        .i_hour(hour), .i_min(mins), .i_sec(secs), .i_humid(humid), .i_temp(temp),
        .i_fifo_full(full_c), .o_fifo_push(push_c), .o_fifo_wr_data(data_c), .o_busy(busy_c)
    );

    resp_tx_cu #(.P_EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .i_report_req(req_l), .i_report_sel(sel_l),
        .i_hour(hour), .i_min(mins), .i_sec(secs), .i_humid(humid), .i_temp(temp),
        .i_fifo_full(full_l), .o_fifo_push(push_l), .o_fifo_wr_data(data_l), .o_busy(busy_l)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int base     = 0;
    int busy_c_cnt = 0, busy_l_cnt = 0;
    int viol_c = 0, viol_l = 0;
    logic [7:0] q_c[$], q_l[$], exp_q[$];
    int st_c[$], st_l[$];

    // Capture every pushed byte with its cycle stamp; flag protocol breaches.
    always @(negedge clk) begin
        cyc++;
        if (push_c) begin q_c.push_back(data_c); st_c.push_back(cyc); end
        if (push_l) begin q_l.push_back(data_l); st_l.push_back(cyc); end
        if (!push_c && data_c !== 8'h00) viol_c++;
        if (!push_l && data_l !== 8'h00) viol_l++;
        if (push_c && full_c) viol_c++;
        if (push_l && full_l) viol_l++;
        if (busy_c) busy_c_cnt++;
        if (busy_l) busy_l_cnt++;
    end

    function automatic void push_dec(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        exp_q.push_back(8'(48 + s / 10));
        exp_q.push_back(8'(48 + s % 10));
    endfunction

    function automatic void build_exp(input bit dht, input bit crlf,
                                      input int h, input int m, input int s,
                                      input int hu, input int t);
        exp_q.delete();
        if (!dht) begin
            push_dec(h); exp_q.push_back(":");
            push_dec(m); exp_q.push_back(":");
            push_dec(s);
        end else begin
            exp_q.push_back("H"); exp_q.push_back(":"); push_dec(hu);
            exp_q.push_back("%"); exp_q.push_back(" ");
            exp_q.push_back("T"); exp_q.push_back(":"); push_dec(t);
            exp_q.push_back("C");
        end
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // -1 on exact match, -2 on length mismatch, else first differing index.
    function automatic int first_diff(input logic [7:0] a[$]);
        if (a.size() != exp_q.size()) return -2;
        foreach (a[i]) if (a[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit lf, input bit dht);
        if (lf) begin q_l.delete(); st_l.delete(); sel_l = dht; req_l = 1'b1; end
        else    begin q_c.delete(); st_c.delete(); sel_c = dht; req_c = 1'b1; end
        tick();
        req_c = 1'b0;
        req_l = 1'b0;
        base = cyc;
        busy_c_cnt = 0;
        busy_l_cnt = 0;
    endtask

    task automatic wait_idle(input bit lf, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!(lf ? busy_l : busy_c)) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (push_c !== 1'b0) $display("FAIL reset_push_c got %b want 0", push_c); else n_pass++;
        n_checks++; if (data_c !== 8'h00) $display("FAIL reset_data_c got %02h want 00", data_c); else n_pass++;
        n_checks++; if (busy_c !== 1'b0) $display("FAIL reset_busy_c got %b want 0", busy_c); else n_pass++;
        n_checks++; if (push_l !== 1'b0) $display("FAIL reset_push_l got %b want 0", push_l); else n_pass++;
        n_checks++; if (busy_l !== 1'b0) $display("FAIL reset_busy_l got %b want 0", busy_l); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_time_crlf();
        bit ok;
        int d;
        hour = 5'd13; mins = 6'd5; secs = 6'd59;
        send(1'b0, 1'b0);
        wait_idle(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL time_timeout got busy want idle"); else n_pass++;
        build_exp(1'b0, 1'b1, 13, 5, 59, 0, 0);
        d = first_diff(q_c);
        n_checks++; if (d !== -1) $display("FAIL time_bytes got size %0d diff %0d want size %0d", q_c.size(), d, exp_q.size()); else n_pass++;
        n_checks++;
        if (st_c.size() != 10 || st_c[0] !== base + 1 || st_c[9] - st_c[0] !== 9)
            $display("FAIL time_timing got n=%0d first=%0d want n=10 first=%0d contiguous", st_c.size(), st_c.size() ? st_c[0] : -1, base + 1);
        else n_pass++;
        n_checks++; if (busy_c_cnt !== 10) $display("FAIL time_busy_cycles got %0d want 10", busy_c_cnt); else n_pass++;
    endtask

    task automatic test_random_reports();
        bit ok, lf, dht;
        int d, h, m, s, hu, t;
        for (int n = 0; n < 8; n++) begin
            lf = 1'($urandom_range(0, 1)); dht = 1'($urandom_range(0, 1));
            h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
            hu = $urandom_range(0, 255); t = $urandom_range(0, 255);
            hour = 5'(h); mins = 6'(m); secs = 6'(s); humid = 8'(hu); temp = 8'(t);
            send(lf, dht);
            wait_idle(lf, 40, ok);
            build_exp(dht, !lf, h, m, s, hu, t);
            d = first_diff(lf ? q_l : q_c);
            n_checks++; if (!ok || d !== -1) $display("FAIL rand_bytes[%0d] got diff %0d idle %b want match", n, d, ok); else n_pass++;
            n_checks++;
            if ((lf ? busy_l_cnt : busy_c_cnt) !== exp_q.size())
                $display("FAIL rand_busy[%0d] got %0d want %0d", n, lf ? busy_l_cnt : busy_c_cnt, exp_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_dht_lf();
        bit ok;
        int d;
        humid = 8'd45; temp = 8'd7;
        send(1'b1, 1'b1);
        tick(); tick(); tick();
        humid = 8'd99; temp = 8'd99;
        wait_idle(1'b1, 40, ok);
        build_exp(1'b1, 1'b0, 0, 0, 0, 45, 7);
        d = first_diff(q_l);
        n_checks++; if (!ok || d !== -1) $display("FAIL dht_lf_bytes got size %0d diff %0d want size %0d", q_l.size(), d, exp_q.size()); else n_pass++;
        n_checks++; if (q_l.size() !== 12) $display("FAIL dht_lf_len got %0d want 12", q_l.size()); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        int d;
        hour = 5'd9; mins = 6'd41; secs = 6'd2;
        send(1'b0, 1'b0);
        repeat (4) tick();
        full_c = 1'b1;
        repeat (3) tick();
        full_c = 1'b0;
        wait_idle(1'b0, 40, ok);
        build_exp(1'b0, 1'b1, 9, 41, 2, 0, 0);
        d = first_diff(q_c);
        n_checks++; if (!ok || d !== -1) $display("FAIL stall_bytes got size %0d diff %0d want size 10", q_c.size(), d); else n_pass++;
        n_checks++;
        if (st_c.size() < 5 || st_c[3] !== base + 4 || st_c[4] !== base + 8)
            $display("FAIL stall_resume got byte5 cycle %0d want %0d", st_c.size() > 4 ? st_c[4] : -1, base + 8);
        else n_pass++;
        n_checks++; if (busy_c_cnt !== 13) $display("FAIL stall_busy_cycles got %0d want 13", busy_c_cnt); else n_pass++;

        for (int n = 0; n < 4; n++) begin
            hour = 5'($urandom_range(0, 31)); humid = 8'($urandom); temp = 8'($urandom);
            build_exp(n[0], 1'b1, int'(hour), int'(mins), int'(secs), int'(humid), int'(temp));
            send(1'b0, n[0]);
            for (int i = 0; i < 200 && busy_c; i++) begin
                full_c = ($urandom_range(0, 9) < 4);
                tick();
            end
            full_c = 1'b0;
            d = first_diff(q_c);
            n_checks++; if (busy_c || d !== -1) $display("FAIL rand_stall[%0d] got size %0d diff %0d want size %0d", n, q_c.size(), d, exp_q.size()); else n_pass++;
        end
    endtask

    task automatic test_req_while_busy();
        bit ok;
        int d;
        humid = 8'd61; temp = 8'd18;
        send(1'b1, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            tick();
            req_l = (k == 3 || k == 11);
            if (k == 2) begin sel_l = 1'b0; humid = 8'd3; end
        end
        req_l = 1'b0;
        build_exp(1'b1, 1'b0, 0, 0, 0, 61, 18);
        d = first_diff(q_l);
        n_checks++; if (d !== -1) $display("FAIL busy_req_bytes got size %0d diff %0d want size 12", q_l.size(), d); else n_pass++;
        n_checks++; if (busy_l !== 1'b0) $display("FAIL busy_req_idle got %b want 0", busy_l); else n_pass++;

        hour = 5'd0; mins = 6'd0; secs = 6'd7;
        send(1'b1, 1'b0);
        wait_idle(1'b1, 40, ok);
        build_exp(1'b0, 1'b0, 0, 0, 7, 0, 0);
        d = first_diff(q_l);
        n_checks++; if (!ok || d !== -1) $display("FAIL busy_req_next got size %0d diff %0d want size 9", q_l.size(), d); else n_pass++;
    endtask

    task automatic test_saturation();
        bit ok;
        int d;
        humid = 8'd120; temp = 8'd255;
        send(1'b0, 1'b1);
        wait_idle(1'b0, 40, ok);
        build_exp(1'b1, 1'b1, 0, 0, 0, 99, 99);
        d = first_diff(q_c);
        n_checks++; if (!ok || d !== -1) $display("FAIL sat_dht got size %0d diff %0d want size 13", q_c.size(), d); else n_pass++;
        n_checks++; if (q_c.size() > 3 && q_c[2] !== 8'h39) $display("FAIL sat_digit got %02h want 39", q_c[2]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        hour = 5'd12; mins = 6'd34; secs = 6'd56;
        send(1'b0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_checks++; if (push_c !== 1'b0) $display("FAIL rstmid_push got %b want 0", push_c); else n_pass++;
        n_checks++; if (data_c !== 8'h00) $display("FAIL rstmid_data got %02h want 00", data_c); else n_pass++;
        n_checks++; if (busy_c !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_c); else n_pass++;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        build_exp(1'b0, 1'b1, 12, 34, 56, 0, 0);
        exp_q = exp_q[0:5];
        d = first_diff(q_c);
        n_checks++; if (d !== -1) $display("FAIL rstmid_count got size %0d diff %0d want size 6", q_c.size(), d); else n_pass++;

        hour = 5'd7; mins = 6'd8; secs = 6'd9;
        send(1'b0, 1'b0);
        wait_idle(1'b0, 40, ok);
        build_exp(1'b0, 1'b1, 7, 8, 9, 0, 0);
        d = first_diff(q_c);
        n_checks++; if (!ok || d !== -1) $display("FAIL rstmid_fresh got size %0d diff %0d want size 10", q_c.size(), d); else n_pass++;
    endtask

    task automatic test_invariants();
        n_checks++; if (viol_c !== 0) $display("FAIL proto_crlf got %0d breaches want 0", viol_c); else n_pass++;
        n_checks++; if (viol_l !== 0) $display("FAIL proto_lf got %0d breaches want 0", viol_l); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_time_crlf();
        test_dht_lf();
        test_stall();
        test_req_while_busy();
        test_saturation();
        test_reset_mid();
        test_random_reports();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
